// File: rtl/parallel_to_serial.sv
// Width-bit parallel word to bit-serial stream, valid/ready on both sides, one-word pending buffer.
// Define P2S_MSB_FIRST_EN to emit parallel_data[width-1] first; default emits bit 0 first.
module parallel_to_serial #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             parallel_valid,
   input  logic [width-1:0] parallel_data,
   output logic             parallel_ready,
   input  logic             serial_ready,
   output logic             serial_valid,
   output logic             serial_data,
   output logic             serial_last
);
   localparam int            CW       = $clog2(width);
   localparam logic [CW-1:0] LAST_IDX = CW'(width - 1);

   logic [width-1:0] r_shift;
   logic [width-1:0] r_pend;
   logic [CW-1:0]    r_cnt;
   logic             r_active;
   logic             r_pend_full;
   logic             r_rdy_en;

   logic w_accept;
   logic w_xfer;
   logic w_last_xfer;
   logic w_direct;

   function automatic logic [width-1:0] shift_next(input logic [width-1:0] s);
`ifdef P2S_MSB_FIRST_EN
      return {s[width-2:0], 1'b0};
`else
      return {1'b0, s[width-1:1]};
`endif
   endfunction

   function automatic logic head_bit(input logic [width-1:0] s);
`ifdef P2S_MSB_FIRST_EN
      return s[width-1];
`else
      return s[0];
`endif
   endfunction

   // r_rdy_en keeps parallel_ready low through reset and rises on the first edge after release
   assign parallel_ready = r_rdy_en & ~r_pend_full;
   assign w_accept       = parallel_valid & parallel_ready;
   assign w_xfer         = r_active & serial_ready;
   assign w_last_xfer    = w_xfer & (r_cnt == LAST_IDX);
   assign w_direct       = w_accept & (~r_active | w_last_xfer);

   assign serial_valid   = r_active;
   assign serial_data    = r_active & head_bit(r_shift);
   assign serial_last    = r_active & (r_cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_pend      <= '0;
         r_cnt       <= '0;
         r_active    <= 1'b0;
         r_pend_full <= 1'b0;
         r_rdy_en    <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_last_xfer) begin
            r_cnt <= '0;
            if (r_pend_full) begin
               r_shift     <= r_pend;
               r_pend      <= '0;
               r_pend_full <= 1'b0;
            end else if (w_accept) begin
               r_shift <= parallel_data;
            end else begin
               r_active <= 1'b0;
               r_shift  <= shift_next(r_shift);
            end
         end else if (w_xfer) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= shift_next(r_shift);
         end else if (w_direct) begin
            r_shift  <= parallel_data;
            r_active <= 1'b1;
         end
         // A word that cannot enter the shifter this edge parks in the pending buffer
         if (w_accept && !w_direct) begin
            r_pend      <= parallel_data;
            r_pend_full <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial (width 8) plus a randomized reassembly check.
// Expected bit order follows P2S_MSB_FIRST_EN when defined.
module tb_parallel_to_serial;
   localparam int W = 8;

   logic         clk            = 1'b0;
   logic         rst_n          = 1'b1;
   logic         parallel_valid = 1'b0;
   logic [W-1:0] parallel_data  = '0;
   logic         serial_ready   = 1'b1;
   logic         parallel_ready;
   logic         serial_valid;
   logic         serial_data;
   logic         serial_last;

   int n_cmp = 0;
   int n_err = 0;

   logic         a5_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic         c3_seq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [W-1:0] b2b    [3] = '{8'h01, 8'h80, 8'hFF};
   logic [W-1:0] sent_q [$];
   logic [W-1:0] asm_w;
   logic         acc;
   int           k, nb, nsent, nrcv, eb;

   parallel_to_serial #(.width(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .parallel_valid (parallel_valid),
      .parallel_data  (parallel_data),
      .parallel_ready (parallel_ready),
      .serial_ready   (serial_ready),
      .serial_valid   (serial_valid),
      .serial_data    (serial_data),
      .serial_last    (serial_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int bitpos(input int i);
`ifdef P2S_MSB_FIRST_EN
      return W - 1 - i;
`else
      return i;
`endif
   endfunction

   function automatic logic ebit(input logic [W-1:0] w, input int i);
      return w[bitpos(i)];
   endfunction

   task automatic expect_word(input logic [W-1:0] w, input string tag);
      parallel_data  = w;
      parallel_valid = 1'b1;
      tick;
      parallel_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         chk({tag, "_valid"}, 32'(serial_valid), 32'(1));
         chk({tag, "_data"},  32'(serial_data),  32'(ebit(w, i)));
         chk({tag, "_last"},  32'(serial_last),  32'(i == W - 1));
         tick;
      end
      chk({tag, "_done"}, 32'(serial_valid), 32'(0));
   endtask

   task automatic b2b_advance;
      k++;
      if (k < 3) parallel_data = b2b[k];
      else       parallel_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state and ready rising one edge after release
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(serial_valid),   32'(0));
      chk("rst_data",  32'(serial_data),    32'(0));
      chk("rst_last",  32'(serial_last),    32'(0));
      chk("rst_ready", 32'(parallel_ready), 32'(0));
      tick;
      tick;
      chk("rst_hold_ready", 32'(parallel_ready), 32'(0));
      rst_n = 1'b1;
      chk("rel_ready_before_edge", 32'(parallel_ready), 32'(0));
      tick;
      chk("rel_ready_after_edge", 32'(parallel_ready), 32'(1));

      // single word A5; data changes while not valid must be ignored
      parallel_data  = 8'hA5;
      parallel_valid = 1'b1;
      tick;
      parallel_valid = 1'b0;
      parallel_data  = 8'hFF;
      for (int i = 0; i < W; i++) begin
         chk("a5_valid", 32'(serial_valid), 32'(1));
         chk("a5_data",  32'(serial_data),  32'(a5_seq[i]));
         chk("a5_last",  32'(serial_last),  32'(i == W - 1));
         tick;
      end
      chk("a5_done", 32'(serial_valid), 32'(0));

      // back-to-back 01, 80, FF with valid held
      k              = 0;
      parallel_data  = b2b[0];
      parallel_valid = 1'b1;
      acc            = parallel_ready;
      tick;
      if (acc) b2b_advance();
      for (int b = 0; b < 3 * W; b++) begin
         chk("b2b_valid", 32'(serial_valid), 32'(1));
         chk("b2b_data",  32'(serial_data),  32'(ebit(b2b[b / W], b % W)));
         chk("b2b_last",  32'(serial_last),  32'((b % W) == W - 1));
         if (b == 1 || b == 9) chk("b2b_ready_low",  32'(parallel_ready), 32'(0));
         if (b == 8 || b == 16) chk("b2b_ready_high", 32'(parallel_ready), 32'(1));
         acc = parallel_valid && parallel_ready;
         tick;
         if (acc) b2b_advance();
      end
      chk("b2b_done", 32'(serial_valid), 32'(0));
      chk("b2b_all_sent", 32'(k), 32'(3));

      // 3C with serial_ready low for 3 cycles while bit 2 is presented
      parallel_data  = 8'h3C;
      parallel_valid = 1'b1;
      tick;
      parallel_valid = 1'b0;
      for (int c = 0; c < W + 3; c++) begin
         eb = (c < 2) ? c : (c <= 5) ? 2 : c - 3;
         chk("stall_valid", 32'(serial_valid), 32'(1));
         chk("stall_data",  32'(serial_data),  32'(c3_seq[eb]));
         chk("stall_last",  32'(serial_last),  32'(c == W + 2));
         serial_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         tick;
      end
      serial_ready = 1'b1;
      chk("stall_done", 32'(serial_valid), 32'(0));

      // reset at bit 4 of F0 with 0F pending
      parallel_data  = 8'hF0;
      parallel_valid = 1'b1;
      tick;
      parallel_data = 8'h0F;
      tick;
      parallel_valid = 1'b0;
      parallel_data  = '0;
      chk("rmw_pend_ready", 32'(parallel_ready), 32'(0));
      tick;
      tick;
      tick;
      chk("rmw_bit4_valid", 32'(serial_valid), 32'(1));
      chk("rmw_bit4_data",  32'(serial_data),  32'(ebit(8'hF0, 4)));
      rst_n = 1'b0;
      #1;
      chk("rmw_rst_valid", 32'(serial_valid),   32'(0));
      chk("rmw_rst_data",  32'(serial_data),    32'(0));
      chk("rmw_rst_ready", 32'(parallel_ready), 32'(0));
      tick;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         chk("rmw_quiet", 32'(serial_valid), 32'(0));
         tick;
      end
      expect_word(8'h5A, "rmw_new");

      // randomized traffic, reassembled and compared in order
      nb    = 0;
      nsent = 0;
      nrcv  = 0;
      asm_w = '0;
      for (int c = 0; c < 4000 && nrcv < 100; c++) begin
         if (!parallel_valid && nsent < 100 && $urandom_range(0, 3) != 0) begin
            parallel_valid = 1'b1;
            parallel_data  = W'($urandom);
         end
         serial_ready = ($urandom_range(0, 2) != 0);
         acc = parallel_valid && parallel_ready;
         if (acc) sent_q.push_back(parallel_data);
         if (serial_valid && serial_ready) begin
            asm_w[bitpos(nb)] = serial_data;
            if (serial_last) begin
               chk("lb_len", 32'(nb), 32'(W - 1));
               if (sent_q.size() == 0) chk("lb_underflow", 32'(1), 32'(0));
               else chk("lb_word", 32'(asm_w), 32'(sent_q.pop_front()));
               nb = 0;
               nrcv++;
            end else begin
               nb++;
            end
         end
         tick;
         if (acc) begin
            parallel_valid = 1'b0;
            nsent++;
         end
      end
      chk("lb_count", 32'(nrcv), 32'(100));
      serial_ready = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
